seven_segment_scan_controller: RTL and testbench

SEVEN_SEGMENT_SCAN_CONTROLLER -- requirements
Module: seven_segment_scan_controller

---
 rtl/seven_seg_pkg.sv | 17 +
 rtl/seven_segment_decoder.sv | 11 +
 rtl/seven_segment_scan_controller.sv | 156 +++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: active-low glyphs and FSM states.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit 0 = segment a ... bit 6 = segment g, low = lit.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational 4-bit value to active-low seven-segment pattern (hex glyphs).
module seven_segment_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = GLYPH[value];

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed seven-segment scanner with per-frame input snapshot, leading-zero blanking,
// blink, PWM brightness and a one-clock anode dead time at the start of every slot.
module seven_segment_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BRIGHT_BITS  = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    state_t                   state;
    logic [PW-1:0]            presc;
    logic [IW-1:0]            idx;
    logic [BRIGHT_BITS-1:0]   pwm_cnt;
    logic [BW-1:0]            blink_cnt;
    logic                     blink_on;

    logic [4*NUM_DIGITS-1:0]  snap_digits;
    logic [NUM_DIGITS-1:0]    snap_dp;
    logic [NUM_DIGITS-1:0]    snap_blink;
    logic                     snap_lz;

    logic [3:0]               cur_val;
    logic                     cur_dp;
    logic                     cur_blink;
    logic                     cur_blank;
    logic                     higher_zero;
    logic [6:0]               dec_seg;
    logic                     blink_off;
    logic [6:0]               seg_next;
    logic                     dp_next;
    logic [NUM_DIGITS-1:0]    an_next;
    logic                     slot_tick;

    assign slot_tick = (presc == PRESC_LAST);

    // Walk from the most significant digit down so higher_zero covers digit i and everything above it.
    always_comb begin
        cur_val     = '0;
        cur_dp      = 1'b0;
        cur_blink   = 1'b0;
        cur_blank   = 1'b0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero & (snap_digits[i*4 +: 4] == 4'd0);
            if (idx == IW'(i)) begin
                cur_val   = snap_digits[i*4 +: 4];
                cur_dp    = snap_dp[i];
                cur_blink = snap_blink[i];
                cur_blank = snap_lz && higher_zero && (i != 0);
            end
        end
    end

    seven_segment_decoder u_decoder (
        .value (cur_val),
        .seg   (dec_seg)
    );

    always_comb begin
        blink_off = cur_blink && !blink_on;
        seg_next  = (cur_blank || blink_off) ? SEG_BLANK : dec_seg;
        dp_next   = !(cur_dp && !blink_off);
        an_next   = '1;
        if (presc != '0 && pwm_cnt <= brightness) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            presc       <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blink  <= '0;
            snap_lz     <= 1'b0;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (state == ST_SCAN && enable) begin
                seg_n   <= seg_next;
                dp_n    <= dp_next;
                an_n    <= an_next;
                pwm_cnt <= pwm_cnt + 1'b1;
                if (slot_tick) begin
                    presc <= '0;
                    if (idx == IDX_LAST) begin
                        idx         <= '0;
                        frame_start <= 1'b1;
                        snap_digits <= digits;
                        snap_dp     <= dp_mask;
                        snap_blink  <= blink_mask;
                        snap_lz     <= blank_lz;
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            blink_on  <= ~blink_on;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end else begin
                // Idle, or the first clock after enable drops: everything parks dark at zero.
                state     <= enable ? ST_SCAN : ST_IDLE;
                presc     <= '0;
                idx       <= '0;
                pwm_cnt   <= '0;
                blink_cnt <= '0;
                blink_on  <= 1'b1;
                seg_n     <= SEG_BLANK;
                dp_n      <= 1'b1;
                an_n      <= '1;
                if (enable) begin
                    snap_digits <= digits;
                    snap_dp     <= dp_mask;
                    snap_blink  <= blink_mask;
                    snap_lz     <= blank_lz;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Self-checking bench: time-based behavioural model compared every cycle, plus directed literal checks.
module tb_seven_segment_scan_controller;

    localparam int N  = 4;
    localparam int CD = 4;
    localparam int BB = 3;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [15:0]   digits = '0;
    logic [3:0]    dp_mask = '0;
    logic [3:0]    blink_mask = '0;
    logic          blank_lz = 1'b0;
    logic [BB-1:0] brightness = '0;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [3:0]    an_n;
    logic          frame_start;

    int checks = 0;
    int failures = 0;

    seven_segment_scan_controller #(
        .NUM_DIGITS   (N),
        .CLK_DIV      (CD),
        .BRIGHT_BITS  (BB),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .digits      (digits),
        .dp_mask     (dp_mask),
        .blink_mask  (blink_mask),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Lit segments as active-high gfedcba; the display pins are the inverse.
    logic [6:0] lit_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: everything derives from t, the clock count since the scan started.
    logic        m_active = 1'b0;
    int          t = 0;
    logic [15:0] s_dig = '0;
    logic [3:0]  s_dp = '0;
    logic [3:0]  s_bl = '0;
    logic        s_lz = 1'b0;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic [3:0]  e_an = 4'hF;
    logic        e_fs = 1'b0;
    int          m_pres, m_slot, m_k;
    logic        m_off, m_blank;

    task automatic take_snapshot();
        s_dig = digits;
        s_dp  = dp_mask;
        s_bl  = blink_mask;
        s_lz  = blank_lz;
    endtask

    task automatic model_step();
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_an  = 4'hF;
        e_fs  = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            t = 0;
            s_dig = '0; s_dp = '0; s_bl = '0; s_lz = 1'b0;
        end else if (!m_active) begin
            if (enable) begin
                m_active = 1'b1;
                t = 0;
                take_snapshot();
            end
        end else if (!enable) begin
            m_active = 1'b0;
        end else begin
            m_pres  = t % CD;
            m_slot  = t / CD;
            m_k     = m_slot % N;
            m_off   = s_bl[m_k] && (((m_slot / N) / BF) % 2 == 1);
            m_blank = s_lz && (m_k != 0) && ((s_dig >> (4 * m_k)) == 16'd0);
            e_seg   = (m_off || m_blank) ? 7'h7F : ~lit_tbl[s_dig[4*m_k +: 4]];
            e_dp    = !(s_dp[m_k] && !m_off);
            if (m_pres != 0 && (t % 8) <= int'(brightness)) e_an = ~(4'b0001 << m_k);
            if (m_pres == CD - 1 && m_k == N - 1) begin
                e_fs = 1'b1;
                take_snapshot();
            end
            t++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_seg", {9'd0, seg_n}, {9'd0, e_seg});
            chk("model_dp", {15'd0, dp_n}, {15'd0, e_dp});
            chk("model_an", {12'd0, an_n}, {12'd0, e_an});
            chk("model_fs", {15'd0, frame_start}, {15'd0, e_fs});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (frame_start !== 1'b1 && n < 64);
        chk("frame_start_wait", {15'd0, frame_start}, 16'd1);
    endtask

    // Call right after sync_frame; samples each digit one clock past its dead time.
    task automatic check_frame(input string nm, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3, input logic [3:0] edp);
        logic [6:0] exp_seg [4];
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        tick(2);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick(4);
            chk({nm, "_seg"}, {9'd0, seg_n}, {9'd0, exp_seg[k]});
            chk({nm, "_dp"}, {15'd0, dp_n}, {15'd0, edp[k]});
        end
    endtask

    task automatic restart_scan();
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(1);
    endtask

    task automatic count_lit(input string nm, input logic [BB-1:0] b, input int exp_cnt);
        int cnt;
        cnt = 0;
        brightness = b;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            if (an_n != 4'hF) cnt++;
        end
        chk(nm, 16'(cnt), 16'(exp_cnt));
    endtask

    logic [3:0] an_tbl [16] = '{
        4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
        4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7
    };

    initial begin
        tick(3);
        chk("reset_seg", {9'd0, seg_n}, 16'h007F);
        chk("reset_dp", {15'd0, dp_n}, 16'd1);
        chk("reset_an", {12'd0, an_n}, 16'h000F);
        chk("reset_fs", {15'd0, frame_start}, 16'd0);

        // Scan order, dead time and first-digit glyph.
        reset = 1'b0;
        enable = 1'b1;
        digits = 16'h1234;
        brightness = 3'd7;
        tick(1);
        chk("entry_dark_an", {12'd0, an_n}, 16'h000F);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            chk("scan_an", {12'd0, an_n}, {12'd0, an_tbl[i]});
            if (i == 1) chk("digit0_glyph4", {9'd0, seg_n}, 16'h0019);
            if (i == 5) chk("digit1_glyph3", {9'd0, seg_n}, 16'h0030);
        end
        chk("first_frame_start", {15'd0, frame_start}, 16'd1);

        // Duty cycle over 64 clocks: lit when presc != 0 and (t mod 8) <= code.
        count_lit("lit_b0", 3'd0, 0);
        count_lit("lit_b3", 3'd3, 24);
        count_lit("lit_b5", 3'd5, 32);
        count_lit("lit_b7", 3'd7, 48);

        // Leading-zero suppression; a blanked digit keeps its decimal point.
        digits = 16'h0040;
        blank_lz = 1'b1;
        dp_mask = 4'b0100;
        sync_frame();
        check_frame("lz_on", 7'h40, 7'h19, 7'h7F, 7'h7F, 4'b1011);
        blank_lz = 1'b0;
        dp_mask = 4'b0000;
        sync_frame();
        check_frame("lz_off", 7'h40, 7'h19, 7'h40, 7'h40, 4'b1111);

        // Mid-frame change is deferred to the next frame.
        digits = 16'h1111;
        sync_frame();
        tick(6);
        chk("mid_d1", {9'd0, seg_n}, 16'h0079);
        digits = 16'h2222;
        tick(4);
        chk("mid_d2_old", {9'd0, seg_n}, 16'h0079);
        tick(4);
        chk("mid_d3_old", {9'd0, seg_n}, 16'h0079);
        sync_frame();
        tick(2);
        chk("next_frame_new", {9'd0, seg_n}, 16'h0024);

        // Hex glyphs.
        digits = 16'hFACE;
        sync_frame();
        check_frame("hex", 7'h06, 7'h46, 7'h08, 7'h0E, 4'b1111);

        // Blink: two frames on, two frames off, restarting from the on-phase.
        digits = 16'h1234;
        blink_mask = 4'b0001;
        dp_mask = 4'b0001;
        restart_scan();
        tick(2);
        for (int f = 0; f < 4; f++) begin
            chk("blink_d0_seg", {9'd0, seg_n}, (f < 2) ? 16'h0019 : 16'h007F);
            chk("blink_d0_dp", {15'd0, dp_n}, (f < 2) ? 16'd0 : 16'd1);
            chk("blink_d0_an", {12'd0, an_n}, 16'h000E);
            tick(4);
            chk("blink_d1_seg", {9'd0, seg_n}, 16'h0030);
            tick(12);
        end

        // Asynchronous reset while digit 2 is showing.
        blink_mask = 4'b0000;
        dp_mask = 4'b0000;
        restart_scan();
        tick(10);
        chk("pre_reset_an", {12'd0, an_n}, 16'h000B);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_seg", {9'd0, seg_n}, 16'h007F);
        chk("async_reset_dp", {15'd0, dp_n}, 16'd1);
        chk("async_reset_an", {12'd0, an_n}, 16'h000F);
        tick(2);
        reset = 1'b0;
        tick(2);
        chk("post_reset_dead", {12'd0, an_n}, 16'h000F);
        tick(1);
        chk("post_reset_an", {12'd0, an_n}, 16'h000E);
        chk("post_reset_seg", {9'd0, seg_n}, 16'h0019);
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
